// File: rtl/mem_copy_engine.sv
// Block-copy engine that drives a single-port word RAM: one read cycle and one write cycle per word.
// Optional running checksum of the words read is enabled by defining MEMCPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
`ifdef MEMCPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef MEMCPY_CHECKSUM_EN
    logic [31:0]       checksum_q;
`endif

    logic [LEN_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] word_off;
    logic [ADDR_W-1:0] next_off;
    logic [ADDR_W-1:0] src_aligned;

    assign idx_inc     = idx_q + 1'b1;
    assign word_off    = ADDR_W'({idx_q, 2'b00});
    assign next_off    = ADDR_W'({idx_inc, 2'b00});
    assign src_aligned = src_addr_i & AlignMask;

    // Addresses are set up one edge ahead so every mem_* output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEMCPY_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        src_q      <= src_aligned;
                        dst_q      <= dst_addr_i & AlignMask;
                        len_q      <= len_i;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
`ifdef MEMCPY_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                        if (len_i != '0) begin
                            state_q <= StRead;
                            addr_q  <= src_aligned;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state_q    <= StWrite;
                    addr_q     <= dst_q + word_off;
                    wdata_q    <= mem_rdata_i;
                    we_q       <= 1'b1;
`ifdef MEMCPY_CHECKSUM_EN
                    checksum_q <= checksum_q + mem_rdata_i;
`endif
                end
                StWrite: begin
                    idx_q <= idx_inc;
                    if (idx_inc == len_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StRead;
                        addr_q  <= src_q + next_off;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
`ifdef MEMCPY_CHECKSUM_EN
    assign checksum_o  = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural word RAM and a write scoreboard.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [5:0]  len = '0;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEMCPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] ram [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] sh [32];
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.LEN_W(6), .ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .src_addr_i  (src_addr),
        .dst_addr_i  (dst_addr),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
`ifdef MEMCPY_CHECKSUM_EN
        ,
        .checksum_o  (checksum)
`endif
    );

    // Async-read, sync-write RAM; every DUT write is logged for the scoreboard.
    assign mem_rdata = ram[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[6:2]] <= mem_wdata;
            obs_q.push_back({mem_addr, mem_wdata});
        end else if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_idx  = 5'(idx);
        pre_data = d;
        tick();
        pre_we   = 1'b0;
        sh[idx]  = d;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) poke(i, 32'h0);
    endtask

    // Forward-copy reference: push each expected write in order.
    task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] as, ad;
        for (int i = 0; i < n; i++) begin
            as = (src & ~32'h3) + 32'(4 * i);
            ad = (dst & ~32'h3) + 32'(4 * i);
            sh[ad[6:2]] = sh[as[6:2]];
            exp_q.push_back({ad, sh[ad[6:2]]});
        end
    endtask

    // Returns in cycle k+1, where k is the edge that samples start.
    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [5:0] n);
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic drain(input string tag);
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_write"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_ram%0d", tag, i), ram[i], sh[i]);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    initial begin
        int we_cnt;
        int done_cnt;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        tick();

        // Basic 4-word copy with cycle-exact busy/done/we
        clear_mem();
        poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
        model_copy(32'h00, 32'h40, 4);
        start_copy(32'h00, 32'h40, 6'd4);
        we_cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            check($sformatf("t1_busy_c%0d", c), busy, (c <= 9));
            check($sformatf("t1_done_c%0d", c), done, (c == 9));
            if (c == 1) check("t1_rd_addr", mem_addr, 32'h00);
            if (c == 2) check("t1_wr_addr", mem_addr, 32'h40);
            if (mem_we) we_cnt++;
            tick();
        end
        check("t1_we_cycles", we_cnt, 4);
        drain("t1");
        check_ram("t1");
        check("t1_word19", ram[19], 32'h44);

        // Zero-length request
        model_copy(32'h10, 32'h20, 0);
        start_copy(32'h10, 32'h20, 6'd0);
        check("t2_busy_c1", busy, 1'b1);
        check("t2_done_c1", done, 1'b1);
        check("t2_we_c1", mem_we, 1'b0);
        tick();
        check("t2_busy_c2", busy, 1'b0);
        check("t2_done_c2", done, 1'b0);
        tick();
        drain("t2");
        check_ram("t2");

        // Overlapping downward move
        clear_mem();
        for (int i = 0; i < 5; i++) poke(i, 32'(i + 1));
        model_copy(32'h04, 32'h00, 4);
        start_copy(32'h04, 32'h00, 6'd4);
        wait_done("t3");
        tick();
        drain("t3");
        check("t3_w0", ram[0], 32'd2);
        check("t3_w3", ram[3], 32'd5);
        check("t3_w4", ram[4], 32'd5);
        check_ram("t3");

        // Start pulse while busy is ignored
        clear_mem();
        poke(0, 32'hA0); poke(1, 32'hA1); poke(2, 32'hA2); poke(3, 32'hA3);
        poke(4, 32'hB4);
        model_copy(32'h00, 32'h40, 4);
        start_copy(32'h00, 32'h40, 6'd4);
        done_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) begin
                src_addr = 32'h10; dst_addr = 32'h60; len = 6'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("t4_done_cycle", c, 9);
            end
            tick();
        end
        check("t4_done_count", done_cnt, 1);
        drain("t4");
        check_ram("t4");

        // Reset mid-transfer: only word 0 lands
        clear_mem();
        poke(0, 32'hC0); poke(1, 32'hC1); poke(2, 32'hC2); poke(3, 32'hC3);
        model_copy(32'h00, 32'h40, 1);
        start_copy(32'h00, 32'h40, 6'd4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_we", mem_we, 1'b0);
        done_cnt = 0;
        we_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) done_cnt++;
            if (mem_we) we_cnt++;
            tick();
        end
        check("t5_no_done", done_cnt, 0);
        check("t5_no_we", we_cnt, 0);
        drain("t5");
        check("t5_word16", ram[16], 32'hC0);
        check("t5_word17", ram[17], 32'h0);
        check_ram("t5");

        // Unaligned source behaves as aligned; checksum wraps mod 2^32
        clear_mem();
        poke(0, 32'hFFFF_FFFF); poke(1, 32'h0000_0002);
        model_copy(32'h03, 32'h40, 2);
        start_copy(32'h03, 32'h40, 6'd2);
        wait_done("t6");
`ifdef MEMCPY_CHECKSUM_EN
        check("t6_checksum", checksum, 32'h1);
`endif
        tick();
        drain("t6");
        check("t6_word16", ram[16], 32'hFFFF_FFFF);
        check_ram("t6");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
